// File: rtl/noc_flit_pkg.sv
// ---------------------------------------------------------------------------
// noc_flit_pkg
// Shared definitions for the NoC flit format used by the injection ROMs and
// the ejection-side checkers.
//
// Flit layout (20 bits):
//   [19:12] src      originating node number
//   [11:8]  reserved must be zero
//   [7:4]   dest     destination node number
//   [3:0]   dest     redundant copy of the destination
//
// Also holds the receive-checker FSM encoding and a saturating counter helper.
// ---------------------------------------------------------------------------
package noc_flit_pkg;

    localparam int FLIT_W     = 20;
    localparam int NODE_W     = 4;
    localparam int SRC_W      = 8;
    localparam int RSV_W      = 4;

    localparam int SRC_MSB    = 19;
    localparam int SRC_LSB    = 12;
    localparam int RSV_MSB    = 11;
    localparam int RSV_LSB    = 8;
    localparam int DST_HI_MSB = 7;
    localparam int DST_HI_LSB = 4;
    localparam int DST_LO_MSB = 3;
    localparam int DST_LO_LSB = 0;

    // Highest node number that exists on the mesh; larger src values are corrupt.
    localparam int MAX_NODE   = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } rx_state_t;

    // 8-bit increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/noc_rx_fifo.sv
// ---------------------------------------------------------------------------
// noc_rx_fifo
// Synchronous single-clock FIFO used as the capture buffer behind the
// ejection-port checker.
//
// Parameters:
//   WIDTH  data width
//   DEPTH  number of entries (power of 2)
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   wr_en     in   write request
//   wr_data   in   data to write
//   wr_ack    out  write request is being accepted this cycle (combinational)
//   rd_en     in   pop request
//   rd_data   out  popped entry, registered, holds when no pop occurs
//   rd_valid  out  one-cycle pulse qualifying rd_data
//   full      out  registered, occupancy == DEPTH
//   empty     out  registered, occupancy == 0
// ---------------------------------------------------------------------------
module noc_rx_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             rd_ok;
    logic             wr_ok;

    // A pop needs data present. A push into a full FIFO is still allowed when
    // a pop frees a slot on the same edge; an empty FIFO cannot do that trick
    // because there is nothing to pop.
    always_comb begin
        rd_ok  = rd_en && !empty;
        wr_ok  = wr_en && (!full || rd_ok);
        wr_ack = wr_ok;
    end

    // Occupancy after this edge; full/empty are registered from it so they
    // always match the occupancy that is in effect after the edge.
    always_comb begin
        count_next = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Storage array carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, status flags and the registered read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + AW'(1);
                rd_data <= mem[rd_ptr];
            end
            rd_valid <= rd_ok;
            count    <= count_next;
            full     <= (count_next == CW'(DEPTH));
            empty    <= (count_next == '0);
        end
    end

endmodule

// File: rtl/datain_chk_buf.sv
// ---------------------------------------------------------------------------
// datain_chk_buf
// Receive-side sink and checker for one NoC node's local ejection port.
// Each valid flit's header is checked against NODE_ID; good flits are kept
// in a drainable capture FIFO, sources that delivered are tracked, and done
// rises once every source in EXPECT_MASK has been seen.
//
// Parameters:
//   NODE_ID      local node number, 0..15
//   DEPTH        capture FIFO entries (power of 2)
//   EXPECT_MASK  sources that must deliver before done
//
// Build option:
//   DATAIN_DUP_DETECT_EN  when defined, a good flit from a source already
//                         marked in seen_mask is treated as bad.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   enable     in   arms reception; flits are dropped while low
//   datain     in   20-bit flit
//   in_valid   in   datain qualifier
//   rd_en      in   capture FIFO pop request
//   rd_data    out  popped flit (registered)
//   rd_valid   out  rd_data qualifier, one-cycle pulse
//   empty      out  FIFO empty
//   full       out  FIFO full
//   seen_mask  out  bit s set once a good flit from src s was stored
//   rx_count   out  good flits stored, saturating
//   err_count  out  bad flits, saturating
//   overflow   out  sticky: a good flit was lost to a full FIFO
//   done       out  all expected sources have delivered
// ---------------------------------------------------------------------------
module datain_chk_buf
    import noc_flit_pkg::*;
#(
    parameter int          NODE_ID     = 9,
    parameter int          DEPTH       = 32,
    parameter logic [15:0] EXPECT_MASK = 16'hFDFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [FLIT_W-1:0] datain,
    input  logic              in_valid,
    input  logic              rd_en,
    output logic [FLIT_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [15:0]       seen_mask,
    output logic [7:0]        rx_count,
    output logic [7:0]        err_count,
    output logic              overflow,
    output logic              done
);

    localparam logic [NODE_W-1:0] NODE_DST = NODE_ID[NODE_W-1:0];
    localparam logic [SRC_W-1:0]  NODE_SRC = SRC_W'(NODE_ID);
    localparam logic [SRC_W-1:0]  SRC_MAX  = SRC_W'(MAX_NODE);

    rx_state_t         state;

    logic [SRC_W-1:0]  f_src;
    logic [RSV_W-1:0]  f_rsv;
    logic [NODE_W-1:0] f_dst_hi;
    logic [NODE_W-1:0] f_dst_lo;

    logic              armed;
    logic              hdr_ok;
    logic              dup_hit;
    logic              flit_good;
    logic              flit_bad;
    logic              fifo_wr_en;
    logic              store;
    logic [15:0]       src_bit;
    logic [15:0]       seen_next;
    logic              done_next;

    // Field split of the incoming flit.
    always_comb begin
        f_src    = datain[SRC_MSB:SRC_LSB];
        f_rsv    = datain[RSV_MSB:RSV_LSB];
        f_dst_hi = datain[DST_HI_MSB:DST_HI_LSB];
        f_dst_lo = datain[DST_LO_MSB:DST_LO_LSB];
    end

    // Header check. A node never receives from itself, so src == NODE_ID is
    // corruption just like an out-of-range src. src_bit is only used once
    // src has been proven to be 0..15.
    always_comb begin
        hdr_ok  = (f_dst_hi == f_dst_lo) &&
                  (f_dst_hi == NODE_DST) &&
                  (f_rsv == '0)          &&
                  (f_src <= SRC_MAX)     &&
                  (f_src != NODE_SRC);
        src_bit = 16'h0001 << f_src[NODE_W-1:0];
`ifdef DATAIN_DUP_DETECT_EN
        dup_hit = |(seen_mask & src_bit);
`else
        dup_hit = 1'b0;
`endif
    end

    // Flits only count while armed (enable high and the FSM out of IDLE).
    // The FIFO decides whether a good flit actually lands; a good flit it
    // refuses is an overflow rather than an error.
    always_comb begin
        armed      = enable && (state != ST_IDLE);
        flit_good  = armed && in_valid && hdr_ok && !dup_hit;
        flit_bad   = armed && in_valid && !(hdr_ok && !dup_hit);
        fifo_wr_en = flit_good;
        seen_next  = store ? (seen_mask | src_bit) : seen_mask;
        done_next  = ((seen_next & EXPECT_MASK) == EXPECT_MASK);
        done       = ((seen_mask & EXPECT_MASK) == EXPECT_MASK);
    end

    noc_rx_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (fifo_wr_en),
        .wr_data  (datain),
        .wr_ack   (store),
        .rd_en    (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .empty    (empty)
    );

    // Reception FSM plus the bookkeeping it owns. RUN moves to DONE on the
    // same edge that stores the last missing source, which is why the
    // transition looks at seen_next rather than the current mask. Dropping
    // enable in RUN parks in IDLE with all counts kept; DONE is sticky.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            seen_mask <= '0;
            rx_count  <= '0;
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (done_next) begin
                        state <= ST_DONE;
                    end else if (!enable) begin
                        state <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase

            if (store) begin
                rx_count  <= sat_inc8(rx_count);
                seen_mask <= seen_next;
            end
            if (flit_bad) begin
                err_count <= sat_inc8(err_count);
            end
            if (flit_good && !store) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_datain_chk_buf.sv
// ---------------------------------------------------------------------------
// tb_datain_chk_buf
// Directed self-checking bench for datain_chk_buf with default parameters
// (NODE_ID=9, DEPTH=32, EXPECT_MASK=16'hFDFF). Inputs change 1 time unit
// after a rising edge and outputs are checked there as well.
// ---------------------------------------------------------------------------
module tb_datain_chk_buf;
    import noc_flit_pkg::*;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [19:0] datain;
    logic        in_valid;
    logic        rd_en;
    logic [19:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [15:0] seen_mask;
    logic [7:0]  rx_count;
    logic [7:0]  err_count;
    logic        overflow;
    logic        done;

    int tests_run;
    int tests_failed;

    datain_chk_buf dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .datain    (datain),
        .in_valid  (in_valid),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .empty     (empty),
        .full      (full),
        .seen_mask (seen_mask),
        .rx_count  (rx_count),
        .err_count (err_count),
        .overflow  (overflow),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one flit for one cycle, optionally with a pop on the same cycle.
    task automatic send(input logic [19:0] flit, input logic pop);
        datain   = flit;
        in_valid = 1'b1;
        rd_en    = pop;
        tick();
        in_valid = 1'b0;
        rd_en    = 1'b0;
    endtask

    task automatic do_reset();
        enable   = 1'b0;
        in_valid = 1'b0;
        rd_en    = 1'b0;
        datain   = '0;
        rst      = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic arm();
        enable = 1'b1;
        tick();
    endtask

    // Good flit for node 9 from the given source.
    function automatic logic [19:0] good_flit(input logic [7:0] src);
        return {src, 4'h0, 4'h9, 4'h9};
    endfunction

    task automatic test_reset();
        do_reset();
        tests_run++; if (rd_data !== 20'h0) begin tests_failed++; $display("[TB] FAIL reset_rd_data got=%h exp=%h", rd_data, 20'h0); end
        tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rd_valid got=%b exp=0", rd_valid); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_empty got=%b exp=1", empty); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_full got=%b exp=0", full); end
        tests_run++; if (seen_mask !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_seen got=%h exp=0000", seen_mask); end
        tests_run++; if (rx_count !== 8'd0 || err_count !== 8'd0) begin tests_failed++; $display("[TB] FAIL reset_counts rx=%0d err=%0d exp=0/0", rx_count, err_count); end
        tests_run++; if (overflow !== 1'b0 || done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_ovf_done ovf=%b done=%b exp=0/0", overflow, done); end
        tests_run++; if (dut.state !== ST_IDLE) begin tests_failed++; $display("[TB] FAIL reset_state got=%0d exp=%0d", dut.state, ST_IDLE); end
    endtask

    task automatic test_single();
        do_reset();
        // A flit in IDLE is ignored.
        send(20'h0F099, 1'b0);
        tests_run++; if (rx_count !== 8'd0 || !empty) begin tests_failed++; $display("[TB] FAIL idle_ignore rx=%0d empty=%b exp=0/1", rx_count, empty); end
        arm();
        tests_run++; if (dut.state !== ST_RUN) begin tests_failed++; $display("[TB] FAIL arm_state got=%0d exp=%0d", dut.state, ST_RUN); end
        send(20'h0F099, 1'b0);
        tests_run++; if (rx_count !== 8'd1) begin tests_failed++; $display("[TB] FAIL single_rx got=%0d exp=1", rx_count); end
        tests_run++; if (seen_mask !== 16'h8000) begin tests_failed++; $display("[TB] FAIL single_seen got=%h exp=8000", seen_mask); end
        tests_run++; if (empty !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_empty got=%b exp=0", empty); end
        rd_en = 1'b1;
        tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL pop_latency_pre got=%b exp=0", rd_valid); end
        tick();
        tests_run++; if (rd_valid !== 1'b1 || rd_data !== 20'h0F099) begin tests_failed++; $display("[TB] FAIL pop_data valid=%b data=%h exp=1/0F099", rd_valid, rd_data); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL pop_empty got=%b exp=1", empty); end
        // Pop on an empty FIFO: no valid, data holds.
        tick();
        rd_en = 1'b0;
        tests_run++; if (rd_valid !== 1'b0 || rd_data !== 20'h0F099) begin tests_failed++; $display("[TB] FAIL empty_pop valid=%b data=%h exp=0/0F099", rd_valid, rd_data); end
    endtask

    task automatic test_bad_flits();
        do_reset();
        arm();
        send(20'h0F0A9, 1'b0);
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL bad_dst_empty got=%b exp=1", empty); end
        send(20'h0F199, 1'b0);
        send(20'h09099, 1'b0);
        tests_run++; if (err_count !== 8'd3) begin tests_failed++; $display("[TB] FAIL bad_err got=%0d exp=3", err_count); end
        tests_run++; if (rx_count !== 8'd0 || seen_mask !== 16'h0) begin tests_failed++; $display("[TB] FAIL bad_rx rx=%0d seen=%h exp=0/0000", rx_count, seen_mask); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("[TB] FAIL bad_empty got=%b exp=1", empty); end
        // Out-of-range source is also bad.
        send(20'h1F099, 1'b0);
        tests_run++; if (err_count !== 8'd4 || rx_count !== 8'd0) begin tests_failed++; $display("[TB] FAIL bad_src err=%0d rx=%0d exp=4/0", err_count, rx_count); end
    endtask

    // Sources 0..8,10..15 in rotation so consecutive entries differ.
    function automatic logic [7:0] rot_src(input int i);
        int s;
        s = i % 15;
        if (s >= 9) s = s + 1;
        return 8'(s);
    endfunction

    task automatic test_overflow();
`ifndef DATAIN_DUP_DETECT_EN
        do_reset();
        arm();
        for (int i = 0; i < 32; i++) begin
            send(good_flit(rot_src(i)), 1'b0);
            if (i == 30) begin
                tests_run++; if (full !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill31_full got=%b exp=0", full); end
            end
        end
        tests_run++; if (full !== 1'b1 || rx_count !== 8'd32) begin tests_failed++; $display("[TB] FAIL fill32 full=%b rx=%0d exp=1/32", full, rx_count); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL fill32_ovf got=%b exp=0", overflow); end
        send(good_flit(8'h03), 1'b0);
        tests_run++; if (overflow !== 1'b1 || rx_count !== 8'd32) begin tests_failed++; $display("[TB] FAIL drop33 ovf=%b rx=%0d exp=1/32", overflow, rx_count); end
        send(good_flit(8'h05), 1'b1);
        tests_run++; if (full !== 1'b1 || rx_count !== 8'd33) begin tests_failed++; $display("[TB] FAIL push_pop_full full=%b rx=%0d exp=1/33", full, rx_count); end
        tests_run++; if (rd_valid !== 1'b1 || rd_data !== 20'h00099) begin tests_failed++; $display("[TB] FAIL push_pop_data valid=%b data=%h exp=1/00099", rd_valid, rd_data); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tests_run++; if (rd_data !== 20'h01099 || full !== 1'b0) begin tests_failed++; $display("[TB] FAIL drain_order data=%h full=%b exp=01099/0", rd_data, full); end
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        arm();
        // Write and read together on an empty FIFO: write wins, no read.
        send(20'h0F099, 1'b1);
        tests_run++; if (rd_valid !== 1'b0 || empty !== 1'b0) begin tests_failed++; $display("[TB] FAIL empty_wr_rd valid=%b empty=%b exp=0/0", rd_valid, empty); end
        send(20'h01099, 1'b1);
        tests_run++; if (rd_valid !== 1'b1 || rd_data !== 20'h0F099 || empty !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_first valid=%b data=%h empty=%b exp=1/0F099/0", rd_valid, rd_data, empty); end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tests_run++; if (rd_data !== 20'h01099 || empty !== 1'b1 || rx_count !== 8'd2) begin tests_failed++; $display("[TB] FAIL b2b_second data=%h empty=%b rx=%0d exp=01099/1/2", rd_data, empty, rx_count); end
    endtask

    task automatic test_done();
        do_reset();
        arm();
        for (int i = 0; i < 15; i++) begin
            if (i == 14) begin
                tests_run++; if (done !== 1'b0 || dut.state !== ST_RUN) begin tests_failed++; $display("[TB] FAIL done_early done=%b state=%0d exp=0/%0d", done, dut.state, ST_RUN); end
            end
            send(good_flit(rot_src(i)), 1'b0);
        end
        tests_run++; if (done !== 1'b1 || seen_mask !== 16'hFDFF) begin tests_failed++; $display("[TB] FAIL done_rise done=%b seen=%h exp=1/FDFF", done, seen_mask); end
        tests_run++; if (dut.state !== ST_DONE) begin tests_failed++; $display("[TB] FAIL done_state got=%0d exp=%0d", dut.state, ST_DONE); end
        enable = 1'b0;
        tick();
        tests_run++; if (done !== 1'b1 || dut.state !== ST_DONE) begin tests_failed++; $display("[TB] FAIL done_hold done=%b state=%0d exp=1/%0d", done, dut.state, ST_DONE); end
    endtask

    task automatic test_disabled_and_reset();
        // Continues from test_done: enable low, 15 flits stored.
        send(20'h03099, 1'b0);
        tests_run++; if (rx_count !== 8'd15 || err_count !== 8'd0 || seen_mask !== 16'hFDFF) begin tests_failed++; $display("[TB] FAIL disabled rx=%0d err=%0d seen=%h exp=15/0/FDFF", rx_count, err_count, seen_mask); end
        enable   = 1'b1;
        datain   = 20'h01099;
        in_valid = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        tests_run++; if (rx_count !== 8'd0 || err_count !== 8'd0 || seen_mask !== 16'h0) begin tests_failed++; $display("[TB] FAIL midreset_counts rx=%0d err=%0d seen=%h exp=0/0/0000", rx_count, err_count, seen_mask); end
        tests_run++; if (empty !== 1'b1 || full !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 20'h0) begin tests_failed++; $display("[TB] FAIL midreset_fifo empty=%b full=%b valid=%b data=%h exp=1/0/0/00000", empty, full, rd_valid, rd_data); end
        tests_run++; if (done !== 1'b0 || overflow !== 1'b0 || dut.state !== ST_IDLE) begin tests_failed++; $display("[TB] FAIL midreset_fsm done=%b ovf=%b state=%0d exp=0/0/%0d", done, overflow, dut.state, ST_IDLE); end
        in_valid = 1'b0;
        enable   = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_duplicates();
        do_reset();
        arm();
        send(20'h03099, 1'b0);
        send(20'h03099, 1'b0);
`ifdef DATAIN_DUP_DETECT_EN
        tests_run++; if (rx_count !== 8'd1 || err_count !== 8'd1) begin tests_failed++; $display("[TB] FAIL dup rx=%0d err=%0d exp=1/1", rx_count, err_count); end
`else
        tests_run++; if (rx_count !== 8'd2 || err_count !== 8'd0) begin tests_failed++; $display("[TB] FAIL dup rx=%0d err=%0d exp=2/0", rx_count, err_count); end
`endif
        tests_run++; if (seen_mask !== 16'h0008) begin tests_failed++; $display("[TB] FAIL dup_seen got=%h exp=0008", seen_mask); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b0;
        enable   = 1'b0;
        in_valid = 1'b0;
        rd_en    = 1'b0;
        datain   = '0;
        test_reset();
        test_single();
        test_bad_flits();
        test_overflow();
        test_back_to_back();
        test_done();
        test_disabled_and_reset();
        test_duplicates();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
